ascon_perm_ctrl: RTL and testbench

Multi-cycle sequencer for the Ascon permutation p^n over a 320-bit state (five 64-bit lanes x0..x4). It owns the state registers, adds round constants, applies a full-width S-box layer, and time-multiplexes one shared rotate/logic unit across the linear layer. It sits beside the rv64 ISE datapath as the coprocessor-style back end for Ascon permutation calls.

---
 rtl/ascon_perm_pkg.sv | 36 +++
 rtl/ascon_rot64.sv | 20 ++
 rtl/ascon_perm_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_ascon_perm_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ascon_perm_pkg.sv
// ascon_perm_pkg: shared types and constants for the Ascon permutation sequencer.
//   state_e      - sequencer states (IDLE/SBOX/LIN/DONE)
//   SBOX_TBL     - 5-bit Ascon S-box; index = {x0,x1,x2,x3,x4} bit-column, x0 in the MSB
//   ROT1/ROT2    - per-lane rotation pairs for the linear layer
//   round_const  - round constant for a given round index
//   LANE_W       - lane width (64)
//   NUM_ROUNDS   - full round count (12)
package ascon_perm_pkg;

  localparam int LANE_W     = 64;
  localparam int NUM_ROUNDS = 12;
  localparam int NUM_LANES  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SBOX = 2'd1,
    ST_LIN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [4:0] SBOX_TBL [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  localparam logic [5:0] ROT1 [NUM_LANES] = '{6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
  localparam logic [5:0] ROT2 [NUM_LANES] = '{6'd28, 6'd39, 6'd6, 6'd17, 6'd41};

  // Constant for round index idx: high nibble counts down from 0xf, low nibble counts up.
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    return {4'hf - idx, idx};
  endfunction

endpackage

// File: rtl/ascon_rot64.sv
// ascon_rot64: combinational 64-bit rotate-right, log-shifter with stages 1/2/4/8/16/32.
//   din   in  64  value to rotate
//   shamt in  6   rotate-right amount
//   dout  out 64  din rotated right by shamt
module ascon_rot64 (
  input  logic [63:0] din,
  input  logic [5:0]  shamt,
  output logic [63:0] dout
);

  logic [63:0] s1, s2, s4, s8, s16;

  assign s1   = shamt[0] ? {din[0],     din[63:1]}  : din;
  assign s2   = shamt[1] ? {s1[1:0],    s1[63:2]}   : s1;
  assign s4   = shamt[2] ? {s2[3:0],    s2[63:4]}   : s2;
  assign s8   = shamt[3] ? {s4[7:0],    s4[63:8]}   : s4;
  assign s16  = shamt[4] ? {s8[15:0],   s8[63:16]}  : s8;
  assign dout = shamt[5] ? {s16[31:0],  s16[63:32]} : s16;

endmodule

// File: rtl/ascon_perm_ctrl.sv
// ascon_perm_ctrl: multi-cycle sequencer for the Ascon permutation p^n.
// Owns the 320-bit state, adds round constants, applies the S-box layer in one
// cycle and walks the linear layer lane by lane through a shared rotate unit.
//   g_clk       in  1    clock
//   g_resetn    in  1    async active-low reset
//   req_valid   in  1    request valid
//   req_ready   out 1    idle, request accepted on req_valid & req_ready
//   req_rounds  in  4    round count n (0 and 13..15 mean 12)
//   req_state   in  320  input state, x0 = [63:0] .. x4 = [319:256]
//   rsp_valid   out 1    result valid
//   rsp_ready   in  1    result accepted
//   rsp_state   out 320  state registers, same packing as req_state
//   busy        out 1    not idle
// Build option ASCON_PERM_DUAL_ROT_EN: two rotate units, one cycle per lane.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// SBOX  | add round constant to x2 and run the S-box layer
// LIN   | linear layer, one lane at a time (two phases per lane unless dual-rot)
// DONE  | result held on rsp_state until rsp_ready
module ascon_perm_ctrl
  import ascon_perm_pkg::*;
(
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_rounds,
  input  logic [319:0] req_state,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [319:0] rsp_state,
  output logic         busy
);

  localparam logic [3:0] RC_START_FULL = 4'd0;
  localparam logic [3:0] RC_LAST       = 4'(NUM_ROUNDS - 1);
  localparam logic [2:0] LANE_LAST     = 3'(NUM_LANES - 1);

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   x_q [NUM_LANES];
  logic [LANE_W-1:0]   x_d [NUM_LANES];
  logic [2:0]          lane_q, lane_d;
  logic [3:0]          rc_idx_q, rc_idx_d;

  logic [3:0]          rc_start;
  logic [7:0]          rc_val;
  logic [LANE_W-1:0]   x2_rc;
  logic [LANE_W-1:0]   sb_x [NUM_LANES];
  logic [4:0]          sb_in, sb_out;
  logic [LANE_W-1:0]   lane_cur;
  logic [LANE_W-1:0]   rot_a;
  logic                lane_step;

  assign lane_cur = x_q[lane_q];

`ifdef ASCON_PERM_DUAL_ROT_EN
  logic [LANE_W-1:0]   rot_b;

  ascon_rot64 u_rot_a (.din(lane_cur), .shamt(ROT1[lane_q]), .dout(rot_a));
  ascon_rot64 u_rot_b (.din(lane_cur), .shamt(ROT2[lane_q]), .dout(rot_b));
`else
  logic                phase_q, phase_d;
  logic [LANE_W-1:0]   t_q, t_d;
  logic [5:0]          rot_amt;

  assign rot_amt = phase_q ? ROT2[lane_q] : ROT1[lane_q];

  ascon_rot64 u_rot (.din(lane_cur), .shamt(rot_amt), .dout(rot_a));
`endif

  // Out-of-range round counts fold to a full p12.
  always_comb begin
    rc_start = RC_START_FULL;
    if (req_rounds != 4'd0 && req_rounds <= 4'(NUM_ROUNDS))
      rc_start = 4'(NUM_ROUNDS) - req_rounds;
  end

  // Constant addition feeds straight into the S-box so SBOX is a single cycle.
  always_comb begin
    rc_val = round_const(rc_idx_q);
    x2_rc  = x_q[2] ^ {{(LANE_W-8){1'b0}}, rc_val};
    sb_in  = 5'd0;
    sb_out = 5'd0;
    sb_x   = x_q;
    for (int b = 0; b < LANE_W; b++) begin
      sb_in      = {x_q[0][b], x_q[1][b], x2_rc[b], x_q[3][b], x_q[4][b]};
      sb_out     = SBOX_TBL[sb_in];
      sb_x[0][b] = sb_out[4];
      sb_x[1][b] = sb_out[3];
      sb_x[2][b] = sb_out[2];
      sb_x[3][b] = sb_out[1];
      sb_x[4][b] = sb_out[0];
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    lane_d    = lane_q;
    rc_idx_d  = rc_idx_q;
    lane_step = 1'b0;
`ifndef ASCON_PERM_DUAL_ROT_EN
    phase_d   = phase_q;
    t_d       = t_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          for (int i = 0; i < NUM_LANES; i++)
            x_d[i] = req_state[i*LANE_W +: LANE_W];
          rc_idx_d = rc_start;
          lane_d   = 3'd0;
`ifndef ASCON_PERM_DUAL_ROT_EN
          phase_d  = 1'b0;
`endif
          state_d  = ST_SBOX;
        end
      end
      ST_SBOX: begin
        x_d     = sb_x;
        lane_d  = 3'd0;
`ifndef ASCON_PERM_DUAL_ROT_EN
        phase_d = 1'b0;
`endif
        state_d = ST_LIN;
      end
      ST_LIN: begin
        // Each lane only reads itself, so the in-place write is exact.
`ifdef ASCON_PERM_DUAL_ROT_EN
        x_d[lane_q] = lane_cur ^ rot_a ^ rot_b;
        lane_step   = 1'b1;
`else
        if (!phase_q) begin
          t_d     = rot_a;
          phase_d = 1'b1;
        end else begin
          x_d[lane_q] = lane_cur ^ t_q ^ rot_a;
          phase_d     = 1'b0;
          lane_step   = 1'b1;
        end
`endif
        if (lane_step) begin
          if (lane_q == LANE_LAST) begin
            lane_d   = 3'd0;
            rc_idx_d = rc_idx_q + 4'd1;
            state_d  = (rc_idx_q == RC_LAST) ? ST_DONE : ST_SBOX;
          end else begin
            lane_d = lane_q + 3'd1;
          end
        end
      end
      ST_DONE: begin
        if (rsp_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q  <= ST_IDLE;
      lane_q   <= 3'd0;
      rc_idx_q <= 4'd0;
      for (int i = 0; i < NUM_LANES; i++)
        x_q[i] <= '0;
`ifndef ASCON_PERM_DUAL_ROT_EN
      phase_q  <= 1'b0;
      t_q      <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      rc_idx_q <= rc_idx_d;
      for (int i = 0; i < NUM_LANES; i++)
        x_q[i] <= x_d[i];
`ifndef ASCON_PERM_DUAL_ROT_EN
      phase_q  <= phase_d;
      t_q      <= t_d;
`endif
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_state = {x_q[4], x_q[3], x_q[2], x_q[1], x_q[0]};

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// tb_ascon_perm_ctrl: directed bench for ascon_perm_ctrl with a bitsliced
// reference model of the Ascon permutation.
module tb_ascon_perm_ctrl;

`ifdef ASCON_PERM_DUAL_ROT_EN
  localparam int ROUND_CYC = 6;
`else
  localparam int ROUND_CYC = 11;
`endif

  localparam logic [7:0] RC_TBL [12] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  logic         g_clk;
  logic         g_resetn;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_rounds;
  logic [319:0] req_state;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [319:0] rsp_state;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  ascon_perm_ctrl u_dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rounds (req_rounds),
    .req_state  (req_state),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_state  (rsp_state),
    .busy       (busy)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic check_val(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ror_m(input logic [63:0] x, input int r);
    return (x >> r) | (x << (64 - r));
  endfunction

  function automatic logic [319:0] model_perm(input logic [319:0] s, input logic [3:0] rounds);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    int n;
    x0 = s[63:0];    x1 = s[127:64];  x2 = s[191:128];
    x3 = s[255:192]; x4 = s[319:256];
    n = (rounds == 4'd0 || rounds > 4'd12) ? 12 : int'(rounds);
    for (int r = 12 - n; r < 12; r++) begin
      x2 = x2 ^ {56'd0, RC_TBL[r]};
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ ror_m(x0, 19) ^ ror_m(x0, 28);
      x1 = x1 ^ ror_m(x1, 61) ^ ror_m(x1, 39);
      x2 = x2 ^ ror_m(x2, 1)  ^ ror_m(x2, 6);
      x3 = x3 ^ ror_m(x3, 10) ^ ror_m(x3, 17);
      x4 = x4 ^ ror_m(x4, 7)  ^ ror_m(x4, 41);
    end
    return {x4, x3, x2, x1, x0};
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] s;
    for (int w = 0; w < 10; w++) s[w*32 +: 32] = $urandom();
    return s;
  endfunction

  // Called #1 after a clock edge with the DUT idle. lat counts clock edges from
  // the accept edge up to and including the edge that raises rsp_valid.
  task automatic run_perm(input logic [319:0] s, input logic [3:0] n,
                          output logic [319:0] res, output int lat);
    req_state  = s;
    req_rounds = n;
    req_valid  = 1'b1;
    lat = 0;
    do begin
      @(posedge g_clk);
      #1;
      lat++;
      req_valid = 1'b0;
    end while (!rsp_valid && lat < 400);
    check_val("rsp_valid_seen", 320'(rsp_valid), 320'd1);
    res = rsp_state;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge g_clk);
    #1;
  endtask

  logic [319:0] res, r12, held, s;
  logic [63:0]  a, x2_exp;
  int lat;

  initial begin
    g_resetn   = 1'b0;
    req_valid  = 1'b0;
    req_rounds = 4'd0;
    req_state  = '0;
    rsp_ready  = 1'b1;
    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    g_resetn = 1'b1;
    @(posedge g_clk);
    #1;
    check_val("rst_req_ready", 320'(req_ready), 320'd1);
    check_val("rst_rsp_valid", 320'(rsp_valid), 320'd0);
    check_val("rst_busy",      320'(busy),      320'd0);
    check_val("rst_rsp_state", rsp_state,       320'd0);

    // Single round on the zero state
    run_perm('0, 4'd1, res, lat);
    check_val("r1_latency", 320'(lat), 320'(ROUND_CYC + 1));
    check_val("r1_x4", 320'(res[319:256]), 320'd0);
    a = 64'h4b;
    x2_exp = ~(a ^ ror_m(a, 1) ^ ror_m(a, 6));
    check_val("r1_x2", 320'(res[191:128]), 320'(x2_exp));
    check_val("r1_full", res, model_perm('0, 4'd1));
    finish_rsp();

    // Full p12 on random states
    for (int k = 0; k < 30; k++) begin
      s = rand_state();
      run_perm(s, 4'd12, res, lat);
      check_val("p12_latency", 320'(lat), 320'(12 * ROUND_CYC + 1));
      check_val("p12_state", res, model_perm(s, 4'd12));
      finish_rsp();
    end

    // Round count mapping
    s = rand_state();
    run_perm(s, 4'd12, r12, lat);
    finish_rsp();
    run_perm(s, 4'd0, res, lat);
    check_val("rounds0_eq_12", res, r12);
    check_val("rounds0_latency", 320'(lat), 320'(12 * ROUND_CYC + 1));
    finish_rsp();
    run_perm(s, 4'd13, res, lat);
    check_val("rounds13_eq_12", res, r12);
    finish_rsp();
    run_perm(s, 4'd6, res, lat);
    check_val("rounds6_state", res, model_perm(s, 4'd6));
    check_val("rounds6_latency", 320'(lat), 320'(6 * ROUND_CYC + 1));
    finish_rsp();
    run_perm(s, 4'd8, res, lat);
    check_val("rounds8_state", res, model_perm(s, 4'd8));
    finish_rsp();

    // Back-pressure on the response
    rsp_ready = 1'b0;
    s = rand_state();
    run_perm(s, 4'd2, held, lat);
    check_val("bp_result", held, model_perm(s, 4'd2));
    req_state = rand_state();
    for (int c = 0; c < 50; c++) begin
      req_valid = c[0];
      @(posedge g_clk);
      #1;
      check_val("bp_state_stable", rsp_state, held);
      check_val("bp_req_ready",    320'(req_ready), 320'd0);
      check_val("bp_rsp_valid",    320'(rsp_valid), 320'd1);
    end
    req_valid = 1'b0;
    finish_rsp();
    check_val("bp_ready_after", 320'(req_ready), 320'd1);

    // Reset in the middle of a p12
    req_state  = rand_state();
    req_rounds = 4'd12;
    req_valid  = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge g_clk);
      #1;
      req_valid = 1'b0;
    end
    check_val("mid_busy_before", 320'(busy), 320'd1);
    #2 g_resetn = 1'b0;
    #1;
    check_val("mid_rst_req_ready", 320'(req_ready), 320'd1);
    check_val("mid_rst_rsp_valid", 320'(rsp_valid), 320'd0);
    check_val("mid_rst_busy",      320'(busy),      320'd0);
    check_val("mid_rst_state",     rsp_state,       320'd0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    @(posedge g_clk);
    #1;
    s = rand_state();
    run_perm(s, 4'd12, res, lat);
    check_val("post_rst_state",   res, model_perm(s, 4'd12));
    check_val("post_rst_latency", 320'(lat), 320'(12 * ROUND_CYC + 1));
    finish_rsp();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
